// File: rtl/bott_total_accum_pkg.sv
// Shared types and BCD constants for the bottle running-total stage and its
// sibling display/price stages.
package bott_total_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CMP  = 2'd2
  } state_t;

  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic [15:0] BCD_SAT16     = 16'h9999;

endpackage

// File: rtl/bott_total_accum_bcd_digit_add.sv
// Single BCD digit adder: s = (a + b + cin) mod 10, cout when the sum exceeds 9.
// Purely combinational so it can be reused by the display and price stages.
module bcd_digit_add
  import bott_total_accum_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  // Binary sum, then fold back into the 0..9 range with a decimal carry.
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    s    = raw[3:0];
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      s    = raw[3:0] - 4'd10;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bott_total_accum.sv
// Running BCD total of committed bottle-counter records. Each change pulse adds
// the pre-clear two-digit snapshot into a 4-digit total, one digit per cycle,
// then updates the record count and the sticky over flag.
module bott_total_accum
  import bott_total_accum_pkg::*;
#(
  parameter logic [15:0] LIMIT = 16'h0500,
  parameter int          CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       num3_1,
  input  logic [3:0]       num2_1,
  input  logic             change,
  output logic [15:0]      total,
  output logic [CNT_W-1:0] count,
  output logic             over,
  output logic             busy,
  output logic             done,
  output logic             dropped
);

  state_t      state, state_nxt;
  logic [1:0]  dig;
  logic [7:0]  snap;
  logic [7:0]  addend;
  logic        carry;
  logic [7:0]  pend;
  logic        pend_vld;
  logic        accept;
  logic [3:0]  dig_a, dig_b, dig_s;
  logic        dig_cout;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Once over is set, new records are ignored outright; work already queued still runs.
  assign accept = change && !over;

  // Digit operands: addend only has tens/units, upper digits add zero plus carry.
  always_comb begin
    dig_a = total[{dig, 2'b00} +: 4];
    dig_b = 4'd0;
    if (dig == 2'd0) dig_b = addend[3:0];
    if (dig == 2'd1) dig_b = addend[7:4];
  end

  bcd_digit_add u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: CMP chains straight into the next add when work is waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (dig == 2'd3) state_nxt = CMP;
      CMP:     state_nxt = (pend_vld || accept) ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Busy covers the whole add/compare sequence.
  always_comb begin
    busy = (state != IDLE);
  end

  // Snapshot, digit-serial accumulate, pending slot and result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap     <= 8'd0;
      addend   <= 8'd0;
      carry    <= 1'b0;
      dig      <= 2'd0;
      pend     <= 8'd0;
      pend_vld <= 1'b0;
      total    <= 16'd0;
      count    <= '0;
      over     <= 1'b0;
      done     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      done    <= 1'b0;
      dropped <= 1'b0;
      // On the change cycle the counter already reads zero, so keep the old value.
      if (!change) snap <= {clamp_bcd(num3_1), clamp_bcd(num2_1)};
      case (state)
        IDLE: begin
          if (accept) begin
            addend <= snap;
            carry  <= 1'b0;
            dig    <= 2'd0;
          end
        end
        ADD: begin
          total[{dig, 2'b00} +: 4] <= dig_s;
          carry <= dig_cout;
          dig   <= dig + 2'd1;
          if (accept) begin
            if (pend_vld) dropped <= 1'b1;
            else begin
              pend     <= snap;
              pend_vld <= 1'b1;
            end
          end
        end
        CMP: begin
          if (carry) begin
            total <= BCD_SAT16;
            over  <= 1'b1;
          end else if (total >= LIMIT) begin
            over <= 1'b1;
          end
          count <= sat_inc(count);
          done  <= 1'b1;
          carry <= 1'b0;
          dig   <= 2'd0;
          if (pend_vld) begin
            addend <= pend;
            if (accept) pend <= snap;
            else        pend_vld <= 1'b0;
          end else if (accept) begin
            addend <= snap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bott_total_accum.sv
// Directed bench for bott_total_accum: table of cumulative records plus
// hand-written sequences for saturation, pending/drop and mid-add reset.
module tb_bott_total_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  num3_1 = 4'd0;
  logic [3:0]  num2_1 = 4'd0;
  logic        change = 1'b0;

  logic [15:0] total_a, total_b;
  logic [7:0]  count_a, count_b;
  logic        over_a, over_b, busy_a, busy_b, done_a, done_b, dropped_a, dropped_b;

  int n_vec  = 0;
  int n_miss = 0;
  int drop_cnt_a = 0;

  always #5 clk = ~clk;

  bott_total_accum #(.LIMIT(16'h0500), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .num3_1(num3_1), .num2_1(num2_1), .change(change),
    .total(total_a), .count(count_a), .over(over_a), .busy(busy_a),
    .done(done_a), .dropped(dropped_a)
  );

  bott_total_accum #(.LIMIT(16'h9999), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .num3_1(num3_1), .num2_1(num2_1), .change(change),
    .total(total_b), .count(count_b), .over(over_b), .busy(busy_b),
    .done(done_b), .dropped(dropped_b)
  );

  always @(negedge clk) if (dropped_a) drop_cnt_a++;

  typedef struct {
    logic [3:0]  t;
    logic [3:0]  u;
    logic [15:0] tot;
    logic [7:0]  cnt;
    logic        ovr;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1; change = 1'b0; num3_1 = 4'd0; num2_1 = 4'd0;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  // Present digits, pulse change, then count edges until the chosen done appears.
  task automatic send(input logic [3:0] t, input logic [3:0] u, input bit use_b, output int lat);
    @(negedge clk) num3_1 = t; num2_1 = u; change = 1'b0;
    @(negedge clk) num3_1 = 4'd0; num2_1 = 4'd0; change = 1'b1;
    @(negedge clk) change = 1'b0;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (use_b ? done_b : done_a) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_done_a(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done_a) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;

    tbl[0] = '{4'd3, 4'd7, 16'h0037, 8'd1, 1'b0};
    tbl[1] = '{4'd5, 4'd8, 16'h0095, 8'd2, 1'b0};
    tbl[2] = '{4'd0, 4'd8, 16'h0103, 8'd3, 1'b0};
    tbl[3] = '{4'd0, 4'd0, 16'h0103, 8'd4, 1'b0};
    tbl[4] = '{4'hF, 4'hC, 16'h0202, 8'd5, 1'b0};
    tbl[5] = '{4'd9, 4'd9, 16'h0301, 8'd6, 1'b0};
    tbl[6] = '{4'd9, 4'd9, 16'h0400, 8'd7, 1'b0};
    tbl[7] = '{4'd8, 4'd0, 16'h0480, 8'd8, 1'b0};
    tbl[8] = '{4'd2, 4'd5, 16'h0505, 8'd9, 1'b1};

    do_reset();
    chk("reset_total", {16'd0, total_a}, 32'h0);
    chk("reset_count", {24'd0, count_a}, 32'h0);
    chk("reset_flags", {28'd0, over_a, busy_a, done_a, dropped_a}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].t, tbl[i].u, 1'b0, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd5);
      chk($sformatf("v%0d_total", i), {16'd0, total_a}, {16'd0, tbl[i].tot});
      chk($sformatf("v%0d_count", i), {24'd0, count_a}, {24'd0, tbl[i].cnt});
      chk($sformatf("v%0d_over", i), {31'd0, over_a}, {31'd0, tbl[i].ovr});
    end

    // Over is set: a new record must be ignored without done or dropped.
    send(4'd1, 4'd1, 1'b0, lat);
    chk("over_ignore_done", lat, 32'hFFFF_FFFF);
    chk("over_ignore_total", {16'd0, total_a}, 32'h0505);
    chk("over_ignore_count", {24'd0, count_a}, 32'd9);
    chk("over_ignore_drop", drop_cnt_a, 32'd0);
    chk("over_ignore_busy", {31'd0, busy_a}, 32'd0);

    // Carry out of the top digit saturates to 9999 (limit raised to 9999).
    do_reset();
    for (int i = 0; i < 100; i++) send(4'd9, 4'd9, 1'b1, lat);
    chk("b_total_9900", {16'd0, total_b}, 32'h9900);
    send(4'd9, 4'd0, 1'b1, lat);
    chk("b_total_9990", {16'd0, total_b}, 32'h9990);
    chk("b_over_low", {31'd0, over_b}, 32'd0);
    send(4'd1, 4'd5, 1'b1, lat);
    chk("b_sat_latency", lat, 32'd5);
    chk("b_sat_total", {16'd0, total_b}, 32'h9999);
    chk("b_sat_over", {31'd0, over_b}, 32'd1);
    chk("b_sat_count", {24'd0, count_b}, 32'd102);

    // Record count saturates at all-ones; zero records still count.
    do_reset();
    for (int i = 0; i < 255; i++) send(4'd0, 4'd0, 1'b1, lat);
    chk("cnt_255", {24'd0, count_b}, 32'hFF);
    send(4'd0, 4'd0, 1'b1, lat);
    chk("cnt_sat_latency", lat, 32'd5);
    chk("cnt_sat", {24'd0, count_b}, 32'hFF);
    chk("cnt_sat_total", {16'd0, total_b}, 32'h0);

    // Three pulses two cycles apart: second goes to pending, third is dropped.
    do_reset();
    drop_cnt_a = 0;
    @(negedge clk) num3_1 = 4'd1; num2_1 = 4'd1; change = 1'b0;
    @(negedge clk) num3_1 = 4'd0; num2_1 = 4'd0; change = 1'b1;
    @(negedge clk) num3_1 = 4'd2; num2_1 = 4'd2; change = 1'b0;
    @(negedge clk) num3_1 = 4'd0; num2_1 = 4'd0; change = 1'b1;
    @(negedge clk) num3_1 = 4'd3; num2_1 = 4'd3; change = 1'b0;
    @(negedge clk) num3_1 = 4'd0; num2_1 = 4'd0; change = 1'b1;
    @(negedge clk) change = 1'b0;
    chk("b2b_dropped", {31'd0, dropped_a}, 32'd1);
    chk("b2b_busy", {31'd0, busy_a}, 32'd1);
    wait_done_a(lat);
    chk("b2b_first_done", lat, 32'd1);
    chk("b2b_first_total", {16'd0, total_a}, 32'h0011);
    wait_done_a(lat);
    chk("b2b_second_done", lat, 32'd5);
    chk("b2b_total", {16'd0, total_a}, 32'h0033);
    chk("b2b_count", {24'd0, count_a}, 32'd2);
    chk("b2b_drop_pulses", drop_cnt_a, 32'd1);
    wait_done_a(lat);
    chk("b2b_no_third", lat, 32'hFFFF_FFFF);

    // Reset while the third digit is being written discards the partial total.
    @(negedge clk) num3_1 = 4'd4; num2_1 = 4'd5; change = 1'b0;
    @(negedge clk) num3_1 = 4'd0; num2_1 = 4'd0; change = 1'b1;
    @(negedge clk) change = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_add_partial", {16'd0, total_a}, 32'h0078);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("mid_reset_total", {16'd0, total_a}, 32'h0);
    chk("mid_reset_count", {24'd0, count_a}, 32'h0);
    chk("mid_reset_busy", {31'd0, busy_a}, 32'd0);
    wait_done_a(lat);
    chk("mid_reset_no_done", lat, 32'hFFFF_FFFF);
    chk("mid_reset_total_hold", {16'd0, total_a}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
